// File: rtl/dca_matrix_step_executor.sv
// dca_matrix_step_executor
//   Executes blocked step instructions from the DCA MRU block controller:
//   optionally pops one NxN block from LSU0, optionally transposes it, and
//   pushes the result (or a zero block) to LSU1.
// Ports:
//   clk, rstnn            clock, asynchronous active-low reset
//   clear, enable         synchronous clear (priority), global enable
//   step_inst_*           step instruction channel {is_last, opcode}
//   rdata_*               LSU0 read block channel; rdata_consumed = read credit
//   wdata_*               LSU1 write block channel; wdata is registered
//   busy, done            not-idle flag, last-step completion pulse

`ifndef BW_DCA_MRU_OPCODE
`define BW_DCA_MRU_OPCODE 4
`endif
`ifndef DCA_MRU_OPCODE_INDEX_LSU0_REQ
`define DCA_MRU_OPCODE_INDEX_LSU0_REQ 0
`endif
`ifndef DCA_MRU_OPCODE_INDEX_TRANSPOSE
`define DCA_MRU_OPCODE_INDEX_TRANSPOSE 1
`endif

module dca_matrix_step_executor #(
  parameter  int MATRIX_SIZE_PARA     = 8,
  parameter  int BW_DATA              = 32,
  localparam int BW_BLOCK             = MATRIX_SIZE_PARA * MATRIX_SIZE_PARA * BW_DATA,
  localparam int BW_BLOCKED_STEP_INST = 1 + `BW_DCA_MRU_OPCODE
) (
  input  logic                            clk,
  input  logic                            rstnn,
  input  logic                            clear,
  input  logic                            enable,
  input  logic                            step_inst_valid,
  output logic                            step_inst_ready,
  input  logic [BW_BLOCKED_STEP_INST-1:0] step_inst,
  input  logic                            rdata_valid,
  output logic                            rdata_ready,
  input  logic [BW_BLOCK-1:0]             rdata,
  output logic                            rdata_consumed,
  output logic                            wdata_valid,
  input  logic                            wdata_ready,
  output logic [BW_BLOCK-1:0]             wdata,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t                state_q;
  logic                  rd_req_q;
  logic                  trans_q;
  logic                  is_last_q;
  logic [BW_BLOCK-1:0]   wdata_q;
  logic [BW_BLOCK-1:0]   rdata_t;

  logic                  active;
  logic                  step_hs;
  logic                  rdata_hs;
  logic                  wdata_hs;
  logic                  inst_rd_req;
  logic                  inst_trans;
  logic                  inst_is_last;
  logic                  opcode_unused;

  assign inst_rd_req   = step_inst[`DCA_MRU_OPCODE_INDEX_LSU0_REQ];
  assign inst_trans    = step_inst[`DCA_MRU_OPCODE_INDEX_TRANSPOSE];
  assign inst_is_last  = step_inst[BW_BLOCKED_STEP_INST-1];
  // Remaining opcode bits carry no meaning for this block.
  assign opcode_unused = ^step_inst;

  // Handshake outputs depend only on state, enable, clear and reset, never on
  // the partner's valid/ready. Gating with rstnn keeps them low during reset.
  assign active          = rstnn & enable & ~clear;
  assign step_inst_ready = active & (state_q == IDLE);
  assign rdata_ready     = active & (state_q == LOAD);
  assign wdata_valid     = active & (state_q == SEND);

  assign step_hs  = step_inst_valid & step_inst_ready;
  assign rdata_hs = rdata_valid & rdata_ready;
  assign wdata_hs = wdata_valid & wdata_ready;

  assign rdata_consumed = rdata_hs;
  assign done           = wdata_hs & is_last_q;
  assign busy           = (state_q != IDLE);
  assign wdata          = wdata_q;

  // Transpose is pure wiring: out(r,c) = in(c,r).
  always_comb begin
    rdata_t = '0;
    for (int unsigned r = 0; r < MATRIX_SIZE_PARA; r++) begin
      for (int unsigned c = 0; c < MATRIX_SIZE_PARA; c++) begin
        rdata_t[(r*MATRIX_SIZE_PARA+c)*BW_DATA +: BW_DATA] =
          rdata[(c*MATRIX_SIZE_PARA+r)*BW_DATA +: BW_DATA];
      end
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q   <= IDLE;
      rd_req_q  <= 1'b0;
      trans_q   <= 1'b0;
      is_last_q <= 1'b0;
      wdata_q   <= '0;
    end else if (clear) begin
      state_q   <= IDLE;
      rd_req_q  <= 1'b0;
      trans_q   <= 1'b0;
      is_last_q <= 1'b0;
      wdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (step_hs) begin
            rd_req_q  <= inst_rd_req;
            trans_q   <= inst_trans;
            is_last_q <= inst_is_last;
            if (inst_rd_req) begin
              state_q <= LOAD;
            end else begin
              wdata_q <= '0;
              state_q <= SEND;
            end
          end
        end
        LOAD: begin
          if (rdata_hs) begin
            wdata_q <= trans_q ? rdata_t : rdata;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (wdata_hs) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dca_matrix_step_executor.md
# dca_matrix_step_executor

Consumer of the blocked step-instruction stream issued by the DCA MRU block controller. Executes one step per instruction:
- pops one N×N data block from the LSU0 read-data channel when the step requests it;
- optionally transposes the block;
- pushes the result onto the LSU1 write-data channel;
- returns one read credit to the controller per block popped, and flags completion of the last step.

## Interface
Parameters:
- MATRIX_SIZE_PARA, 8, block dimension N (N×N elements per block)
- BW_DATA, 32, element width in bits
- Derived: BW_BLOCK = N*N*BW_DATA; BW_BLOCKED_STEP_INST = 1 + `BW_DCA_MRU_OPCODE

Ports (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge
- rstnn  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear to reset state
- enable  in  1  global enable; gates all state updates and handshakes
- step_inst_valid  in  1  step instruction valid
- step_inst_ready  out  1  step instruction accepted
- step_inst  in  BW_BLOCKED_STEP_INST  {is_last, opcode}
- rdata_valid  in  1  LSU0 read block valid
- rdata_ready  out  1  LSU0 read block popped
- rdata  in  BW_BLOCK  element (r,c) at bits [(r*N+c)*BW_DATA +: BW_DATA]
- rdata_consumed  out  1  one-cycle credit pulse, asserted on every rdata handshake
- wdata_valid  out  1  LSU1 write block valid
- wdata_ready  in  1  LSU1 accepts block
- wdata  out  BW_BLOCK  result block, same element layout as rdata
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse on wdata handshake of an is_last step

## Operation
- Opcode decode:
  - rd_req = opcode[`DCA_MRU_OPCODE_INDEX_LSU0_REQ]
  - trans = opcode[`DCA_MRU_OPCODE_INDEX_TRANSPOSE]
  - is_last = step_inst MSB
  - Other opcode bits are ignored.
- FSM states: IDLE, LOAD, SEND.
- IDLE:
  - step_inst_ready = enable.
  - On handshake, latch rd_req, trans and is_last.
  - If rd_req, go to LOAD.
  - Otherwise load wdata with all zeros and go to SEND.
- LOAD:
  - rdata_ready = enable.
  - On handshake, wdata register is loaded with rdata (trans=0) or with its transpose (trans=1: out(r,c) = in(c,r)). Then go to SEND.
  - rdata_consumed = rdata_valid & rdata_ready.
- SEND:
  - wdata_valid = enable.
  - On handshake, go to IDLE; done = 1 in the same cycle if the latched is_last is set.
- Only one step is in flight. step_inst_ready is 0 outside IDLE, and rdata_ready is 0 outside LOAD.
- enable = 0: all ready/valid outputs are forced 0, state and registers hold, and no pulses are generated.
- clear = 1 (takes priority over enable):
  - next cycle: FSM = IDLE, latched fields = 0, wdata = 0;
  - no handshake completes in the clear cycle; all handshake outputs are 0 while clear is high.
- Reset: FSM = IDLE, all registers 0.
  - Output values in reset: step_inst_ready = 0 during reset (combinational on enable, IDLE); rdata_ready = 0, wdata_valid = 0, rdata_consumed = 0, done = 0, busy = 0, wdata = 0.
- Reset mid-step discards the block. No credit is returned for a block that was not handshaken.

## Timing
- Step handshake in cycle T.
- With rd_req:
  - rdata_ready is high from T+1.
  - Read handshake in cycle R ≥ T+1, with rdata_consumed pulsed in R.
  - wdata_valid is high from R+1.
- Without rd_req: wdata_valid (zero block) is high from T+1.
- Write handshake in cycle W. step_inst_ready is high again from W+1.
- Minimum throughput: 3 cycles per rd_req step, 2 cycles per non-read step.
- Valid/ready outputs are combinational from FSM state and enable only. They must never depend combinationally on the partner's valid or ready.
- wdata comes directly from a register. The transpose is a pure wiring permutation at the register input.
- Back-to-back: a step_inst_valid held high through W is accepted at W+1, not at W.

## Test plan
- Identity:
  - Stimulus: N=8, rd_req=1, trans=0, rdata element (r,c) = r*8+c, all partners always ready/valid.
  - Required response: step accepted at T; rdata handshake and rdata_consumed=1 at T+1; wdata_valid at T+2 with wdata == rdata.
- Transpose:
  - Stimulus: same input block with trans=1.
  - Required response: wdata element (2,5) = 42 and (5,2) = 21; the diagonal is unchanged.
- No-read step:
  - Stimulus: rd_req=0, trans=1, is_last=1, rdata_valid=1 throughout.
  - Required response: rdata_ready is never asserted; rdata_consumed stays 0; wdata = 0 at T+1; done=1 at the write handshake.
- Backpressure and stalls:
  - Stimulus: wdata_ready low for 4 cycles; enable low for 3 cycles while in LOAD with rdata_valid high.
  - Required response: no handshake and no credit while enable=0; wdata stays stable while wdata_valid is high; exactly one rdata_consumed pulse per block.
- Sequence:
  - Stimulus: 4 steps, is_last on the 4th, with step_inst_valid held high.
  - Required response: steps accepted at cycles 0, 3, 6, 9; 4 rdata_consumed pulses; exactly 1 done pulse, on the 4th write; busy falls after it.
- Clear/reset:
  - Stimulus: assert clear while in SEND, then rstnn low while in LOAD.
  - Required response: FSM returns to IDLE; wdata = 0; done = 0; no extra rdata_consumed pulse; the next step then executes normally.
